semaforo_secuenciador: RTL and testbench

//  Phase sequencer directly upstream of the turn and pedestrian light FSMs.

---
 rtl/semaforo_pkg.sv | 29 ++
 rtl/ped_req_sync.sv | 64 ++++++
 rtl/semaforo_secuenciador.sv | 189 ++++++++++++++++++
 tb/tb_semaforo_secuenciador.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_pkg
// Description : Shared definitions for the intersection phase sequencer.
//               Phase state encodings (also visible on the phase debug port)
//               and the 2-bit light codes reported by the downstream light
//               FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
package semaforo_pkg;

    // Phase encodings. Values 6 and 7 are unused and recover to S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_CLR1  = 3'd2,
        S_A_GRN = 3'd3,
        S_CLR2  = 3'd4,
        S_B_GRN = 3'd5
    } state_t;

    // Light codes driven by the downstream light FSMs.
    localparam logic [1:0] OFF   = 2'b00;
    localparam logic [1:0] RED   = 2'b01;
    localparam logic [1:0] GREEN = 2'b10;
    localparam logic [1:0] ERROR = 2'b11;

endpackage : semaforo_pkg
`default_nettype wire

// File: rtl/ped_req_sync.sv
`default_nettype none
// ============================================================================
// Module      : ped_req_sync
// Description : Pedestrian request front end. Two-flop synchronizer on the
//               asynchronous push button, rising-edge detect, and a pending
//               latch that holds the request until the sequencer grants it.
//               Only built when PED_REQ_EN is defined.
// Ports       : clklf    in  1  low-frequency clock, posedge
//               reset    in  1  synchronous, active-high
//               run      in  1  intersection enable; 0 drops any request
//               ped_req  in  1  raw asynchronous push button
//               grant    in  1  sequencer is serving the request this cycle
//               ped_pend out 1  a request is waiting to be served
// Macro       : PED_REQ_EN (whole module compiled only when defined)
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef PED_REQ_EN
module ped_req_sync (
    input  logic clklf,
    input  logic reset,
    input  logic run,
    input  logic ped_req,
    input  logic grant,
    output logic ped_pend
);

    logic sync1_q, sync2_q, prev_q, pend_q;
    logic pend_d;
    logic rise;

    assign rise = sync2_q & ~prev_q;

    // A grant takes priority over a new edge in the same cycle: that edge is
    // considered served by the grant.
    always_comb begin
        pend_d = pend_q;
        if (!run) begin
            pend_d = 1'b0;
        end else if (grant) begin
            pend_d = 1'b0;
        end else if (rise) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clklf) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= ped_req;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
        end
    end

    assign ped_pend = pend_q;

endmodule : ped_req_sync
`endif
`default_nettype wire

// File: rtl/semaforo_secuenciador.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_secuenciador
// Description : Phase sequencer for a vehicle-turn light (A) and a pedestrian
//               light (B). Cycles all-red clearance, A green, all-red
//               clearance, B green. Emits single-cycle change pulses so each
//               downstream light toggles once per phase edge. All outputs are
//               registered alongside the state.
// Ports       : clklf    in  1  low-frequency clock, posedge
//               reset    in  1  synchronous, active-high
//               run      in  1  intersection enable; 0 = lights off
//               ped_req  in  1  pedestrian button (async)
//               en_o     out 1  enable to both light FSMs
//               set_o    out 1  load RED into both light FSMs
//               change_a out 1  toggle pulse, light A
//               change_b out 1  toggle pulse, light B
//               phase    out 3  current state encoding
//               ped_ack  out 1  pulse when a pedestrian request is granted
// Macro       : PED_REQ_EN - B phase only on pedestrian demand; otherwise
//               B always follows CLR2, ped_req is ignored, ped_ack is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_secuenciador
    import semaforo_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int T_CLR = 2,
    parameter int T_A   = 10,
    parameter int T_B   = 8
) (
    input  logic       clklf,
    input  logic       reset,
    input  logic       run,
    input  logic       ped_req,
    output logic       en_o,
    output logic       set_o,
    output logic       change_a,
    output logic       change_b,
    output logic [2:0] phase,
    output logic       ped_ack
);

    // Timer reload values: a state lasting T cycles loads T-1 on entry and
    // exits in the cycle the timer reads zero.
    localparam logic [CNT_W-1:0] C_LD_CLR = CNT_W'(T_CLR - 1);
    localparam logic [CNT_W-1:0] C_LD_A   = CNT_W'(T_A - 1);
    localparam logic [CNT_W-1:0] C_LD_B   = CNT_W'(T_B - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             en_q, en_d;
    logic             set_q, set_d;
    logic             change_a_q, change_a_d;
    logic             change_b_q, change_b_d;
    logic             ped_ack_q, ped_ack_d;
    logic             timer_done;

    assign timer_done = (timer_q == '0);

`ifdef PED_REQ_EN
    logic ped_pend;
    logic ped_grant;

    ped_req_sync u_ped_req_sync (
        .clklf    (clklf),
        .reset    (reset),
        .run      (run),
        .ped_req  (ped_req),
        .grant    (ped_grant),
        .ped_pend (ped_pend)
    );

    assign ped_grant = run && (state_q == S_CLR2) && timer_done && ped_pend;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        change_a_d = 1'b0;
        change_b_d = 1'b0;
        ped_ack_d  = 1'b0;

        if (!run) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_START;
                    timer_d = '0;
                end
                S_START: begin
                    state_d = S_CLR1;
                    timer_d = C_LD_CLR;
                end
                S_CLR1: begin
                    if (timer_done) begin
                        state_d    = S_A_GRN;
                        timer_d    = C_LD_A;
                        change_a_d = 1'b1;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_A_GRN: begin
                    if (timer_done) begin
                        state_d    = S_CLR2;
                        timer_d    = C_LD_CLR;
                        change_a_d = 1'b1;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_CLR2: begin
                    if (timer_done) begin
`ifdef PED_REQ_EN
                        if (ped_pend) begin
                            state_d    = S_B_GRN;
                            timer_d    = C_LD_B;
                            change_b_d = 1'b1;
                            ped_ack_d  = 1'b1;
                        end else begin
                            // No demand: skip B and go straight back to A.
                            state_d    = S_A_GRN;
                            timer_d    = C_LD_A;
                            change_a_d = 1'b1;
                        end
`else
                        state_d    = S_B_GRN;
                        timer_d    = C_LD_B;
                        change_b_d = 1'b1;
`endif
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_B_GRN: begin
                    if (timer_done) begin
                        state_d    = S_CLR1;
                        timer_d    = C_LD_CLR;
                        change_b_d = 1'b1;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // Level outputs follow the next state so they line up with it.
        en_d  = (state_d != S_IDLE);
        set_d = (state_d == S_START);
    end

    always_ff @(posedge clklf) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            en_q       <= 1'b0;
            set_q      <= 1'b0;
            change_a_q <= 1'b0;
            change_b_q <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            en_q       <= en_d;
            set_q      <= set_d;
            change_a_q <= change_a_d;
            change_b_q <= change_b_d;
            ped_ack_q  <= ped_ack_d;
        end
    end

    assign en_o     = en_q;
    assign set_o    = set_q;
    assign change_a = change_a_q;
    assign change_b = change_b_q;
    assign phase    = state_q;
    assign ped_ack  = ped_ack_q;

endmodule : semaforo_secuenciador
`default_nettype wire

// File: tb/tb_semaforo_secuenciador.sv
`default_nettype none
// ============================================================================
// Module      : tb_semaforo_secuenciador
// Description : Directed self-checking bench for semaforo_secuenciador. Two
//               instances: default timing (u_dut) and T_A=T_CLR=1, T_B=2
//               (u_dut1). Simple light models on the outputs report the
//               resulting light colours.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semaforo_secuenciador;
    import semaforo_pkg::*;

    logic clklf = 1'b0;
    always #5 clklf = ~clklf;

    logic       reset, run, ped_req;
    logic       en_o, set_o, change_a, change_b, ped_ack;
    logic [2:0] phase;
    logic       reset1, run1;
    logic       en1, set1, ca1, cb1, ack1;
    logic [2:0] ph1;
    logic [1:0] la, lb, la1;

    int cyc;
    int n_checks = 0;
    int n_errors = 0;

    semaforo_secuenciador u_dut (
        .clklf(clklf), .reset(reset), .run(run), .ped_req(ped_req),
        .en_o(en_o), .set_o(set_o), .change_a(change_a), .change_b(change_b),
        .phase(phase), .ped_ack(ped_ack)
    );

    semaforo_secuenciador #(.CNT_W(8), .T_CLR(1), .T_A(1), .T_B(2)) u_dut1 (
        .clklf(clklf), .reset(reset1), .run(run1), .ped_req(1'b0),
        .en_o(en1), .set_o(set1), .change_a(ca1), .change_b(cb1),
        .phase(ph1), .ped_ack(ack1)
    );

    // Reference light FSM: off when disabled, RED on set, toggle on change.
    function automatic logic [1:0] light_nx(input logic rst, input logic en,
                                            input logic set, input logic chg,
                                            input logic [1:0] cur);
        if (rst || !en) return OFF;
        if (set)        return RED;
        if (chg)        return (cur == GREEN) ? RED : GREEN;
        return cur;
    endfunction

    always @(posedge clklf) begin
        la  <= light_nx(reset,  en_o, set_o, change_a, la);
        lb  <= light_nx(reset,  en_o, set_o, change_b, lb);
        la1 <= light_nx(reset1, en1,  set1,  ca1,      la1);
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clklf);
            #1;
            cyc++;
        end
    endtask

    int k, na, nb, both, stray, exp_ph, exp_ca, exp_cb;

    initial begin
        reset = 1'b1; run = 1'b0; ped_req = 1'b0;
        reset1 = 1'b1; run1 = 1'b0;
        cyc = 0;
        tick(2);

        // ---- reset state
        chk("rst_phase", phase, 0);
        chk("rst_en", en_o, 0);
        chk("rst_set", set_o, 0);
        chk("rst_chg", {change_a, change_b, ped_ack}, 0);

        // ---- 1: start-up sequence
        reset = 1'b0; run = 1'b1; cyc = 0;
        tick(1);
        chk("start_phase", phase, 1);
        chk("start_en", en_o, 1);
        chk("start_set", set_o, 1);
        tick(1);
        chk("clr1_phase", phase, 2);
        chk("clr1_set", set_o, 0);
        chk("clr1_lights", {la, lb}, {RED, RED});
        tick(1);
        chk("clr1b_phase", phase, 2);
        tick(1);
        chk("agrn_phase", phase, 3);
        chk("agrn_pulse", change_a, 1);
        tick(1);
        chk("agrn_light", la, GREEN);
        chk("agrn_pulse_end", change_a, 0);

`ifndef PED_REQ_EN
        // ---- 2: one full 22-cycle period, cycle-by-cycle phase model
        na = 0; nb = 0; both = 0;
        for (int i = 0; i < 22; i++) begin
            tick(1);
            k = (cyc - 2) % 22;
            exp_ph = (k < 2) ? 2 : (k < 12) ? 3 : (k < 14) ? 4 : 5;
            exp_ca = (k == 2 || k == 12) ? 1 : 0;
            exp_cb = (k == 14 || k == 0) ? 1 : 0;
            chk("loop_phase", phase, exp_ph);
            chk("loop_ca", change_a, exp_ca);
            chk("loop_cb", change_b, exp_cb);
            if (change_a) na++;
            if (change_b) nb++;
            if (la == GREEN && lb == GREEN) both++;
        end
        chk("period_na", na, 2);
        chk("period_nb", nb, 2);
        chk("never_both_green", both, 0);
`endif

        // ---- 3: run=0 mid-A_GRN, then restart
        chk("pre_stop_phase", phase, 3);
        run = 1'b0;
        tick(1);
        chk("stop_phase", phase, 0);
        chk("stop_en", en_o, 0);
        chk("stop_chg", {change_a, change_b}, 0);
        tick(1);
        chk("stop_lights", {la, lb}, {OFF, OFF});
        run = 1'b1;
        tick(1);
        chk("restart_phase", phase, 1);
        chk("restart_set", set_o, 1);
        tick(1);
        chk("restart_lights", {la, lb}, {RED, RED});
        cyc = 2;

`ifndef PED_REQ_EN
        // ---- 4: reset mid-B_GRN
        tick(16);
        chk("bgrn_phase", phase, 5);
        chk("bgrn_light", lb, GREEN);
        reset = 1'b1;
        tick(1);
        chk("rst2_phase", phase, 0);
        chk("rst2_outs", {en_o, set_o, change_a, change_b, ped_ack}, 0);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (change_a || change_b || en_o) stray++;
        end
        chk("rst2_no_stray", stray, 0);
        chk("rst2_lights", {la, lb}, {OFF, OFF});
        reset = 1'b0;
        tick(1);
        chk("rst2_restart", phase, 1);
`else
        // ---- 5: pedestrian request gating
        reset = 1'b1;
        tick(2);
        reset = 1'b0; cyc = 0;
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (change_b) nb++;
        end
        chk("ped_skip_phase", phase, 3);
        chk("ped_skip_ca", change_a, 1);
        chk("ped_skip_nb", nb, 0);
        tick(2);
        ped_req = 1'b1;
        tick(3);
        ped_req = 1'b0;
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (change_b || ped_ack) nb++;
        end
        chk("ped_early", nb, 0);
        chk("ped_clr2", phase, 4);
        tick(1);
        chk("ped_bgrn_phase", phase, 5);
        chk("ped_bgrn_cb", change_b, 1);
        chk("ped_ack", ped_ack, 1);
        tick(1);
        chk("ped_ack_end", ped_ack, 0);
`endif

        // ---- 6: single-cycle phases on the short-timing instance
        reset1 = 1'b0; run1 = 1'b1; cyc = 0;
        tick(1);
        chk("s_start", ph1, 1);
        tick(1);
        chk("s_clr1", ph1, 2);
        tick(1);
        chk("s_agrn", ph1, 3);
        chk("s_agrn_ca", ca1, 1);
        tick(1);
        chk("s_clr2", ph1, 4);
        chk("s_clr2_ca", ca1, 1);
        chk("s_la_green", la1, GREEN);
        tick(1);
        chk("s_la_red", la1, RED);
`ifndef PED_REQ_EN
        chk("s_bgrn", ph1, 5);
        chk("s_bgrn_pulses", {ca1, cb1}, 2'b01);
        tick(2);
        chk("s_clr1_again", ph1, 2);
        chk("s_clr1_cb", cb1, 1);
`else
        chk("s_skip_agrn", ph1, 3);
        chk("s_skip_ca", ca1, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_semaforo_secuenciador
`default_nettype wire
